// File: rtl/ps2_line_interpreter.sv
// ps2_line_interpreter: parses a NUL-padded 32-char ASCII command line one char per clock.
// Ports: clock, reset_n, input_line[255:0], line_ready in; velocity, angle, fire, reset, busy, cmd_error out.
// Optional: define PS2_INTERP_ANGLE_RANGE_EN to reject angle values above 359.
module ps2_line_interpreter (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [255:0] input_line,
    input  logic         line_ready,
    output logic [31:0]  velocity,
    output logic [31:0]  angle,
    output logic         fire,
    output logic         reset,
    output logic         busy,
    output logic         cmd_error
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_NUM, S_TAIL} state_t;
    typedef enum logic [1:0] {C_VEL, C_ANG, C_FIRE, C_RST} cmd_t;

    state_t        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic [255:0]  buf_q, buf_d;
    logic [4:0]    idx_q, idx_d;
    logic [31:0]   acc_q, acc_d;
    logic          has_dig_q, has_dig_d;
    logic [31:0]   velocity_q, velocity_d;
    logic [31:0]   angle_q, angle_d;
    logic          fire_q, fire_d;
    logic          reset_q, reset_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic [7:0]    ch;
    logic [7:0]    up;
    logic          is_nul;
    logic          is_dig;
    logic          last;
    logic [35:0]   acc_wide;
    logic [31:0]   acc_next;
    logic          do_commit;
    logic          do_err;
    logic [31:0]   commit_val;

    // The buffer shifts left each cycle, so the current char is always the top byte.
    assign ch     = buf_q[255:248];
    assign up     = ch & 8'hDF;
    assign is_nul = (ch == 8'h00);
    assign is_dig = (ch >= 8'h30) && (ch <= 8'h39);
    assign last   = (idx_q == 5'd31);

    // acc*10 + digit in 36 bits; any carry past bit 31 saturates.
    assign acc_wide = ({4'd0, acc_q} << 3) + ({4'd0, acc_q} << 1)
                    + {32'd0, ch[3:0]};
    assign acc_next = (acc_wide[35:32] != 4'd0) ? 32'hFFFF_FFFF
                                                : acc_wide[31:0];

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        buf_d      = buf_q << 8;
        idx_d      = idx_q + 5'd1;
        acc_d      = acc_q;
        has_dig_d  = has_dig_q;
        velocity_d = velocity_q;
        angle_d    = angle_q;
        fire_d     = 1'b0;
        reset_d    = 1'b0;
        busy_d     = busy_q;
        err_d      = 1'b0;
        do_commit  = 1'b0;
        do_err     = 1'b0;
        commit_val = acc_q;

        case (state_q)
            S_IDLE: begin
                buf_d = buf_q;
                idx_d = idx_q;
                if (line_ready) begin
                    buf_d   = input_line;
                    idx_d   = 5'd0;
                    state_d = S_CMD;
                    busy_d  = 1'b1;
                end
            end
            S_CMD: begin
                unique case (1'b1)
                    is_nul: begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                    (up == 8'h56): begin
                        cmd_d     = C_VEL;
                        acc_d     = 32'd0;
                        has_dig_d = 1'b0;
                        state_d   = S_NUM;
                    end
                    (up == 8'h41): begin
                        cmd_d     = C_ANG;
                        acc_d     = 32'd0;
                        has_dig_d = 1'b0;
                        state_d   = S_NUM;
                    end
                    (up == 8'h46): begin
                        cmd_d   = C_FIRE;
                        state_d = S_TAIL;
                    end
                    (up == 8'h52): begin
                        cmd_d   = C_RST;
                        state_d = S_TAIL;
                    end
                    default: do_err = 1'b1;
                endcase
            end
            S_NUM: begin
                unique case (1'b1)
                    is_dig: begin
                        acc_d     = acc_next;
                        has_dig_d = 1'b1;
                        // A digit in the final slot also ends the line.
                        if (last) begin
                            do_commit  = 1'b1;
                            commit_val = acc_next;
                        end
                    end
                    is_nul: begin
                        if (has_dig_q) do_commit = 1'b1;
                        else           do_err    = 1'b1;
                    end
                    default: do_err = 1'b1;
                endcase
            end
            S_TAIL: begin
                if (is_nul) do_commit = 1'b1;
                else        do_err    = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (do_err) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end

        if (do_commit) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            case (cmd_q)
                C_VEL:  velocity_d = commit_val;
                C_ANG: begin
`ifdef PS2_INTERP_ANGLE_RANGE_EN
                    if (commit_val > 32'd359) err_d   = 1'b1;
                    else                      angle_d = commit_val;
`else
                    angle_d = commit_val;
`endif
                end
                C_FIRE: fire_d  = 1'b1;
                C_RST:  reset_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= C_VEL;
            buf_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            has_dig_q  <= 1'b0;
            velocity_q <= '0;
            angle_q    <= '0;
            fire_q     <= 1'b0;
            reset_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            has_dig_q  <= has_dig_d;
            velocity_q <= velocity_d;
            angle_q    <= angle_d;
            fire_q     <= fire_d;
            reset_q    <= reset_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign velocity  = velocity_q;
    assign angle     = angle_q;
    assign fire      = fire_q;
    assign reset     = reset_q;
    assign busy      = busy_q;
    assign cmd_error = err_q;

endmodule

// File: tb/tb_ps2_line_interpreter.sv
// tb_ps2_line_interpreter: scoreboard bench for ps2_line_interpreter.
// Expected end-of-line snapshots are queued by the stimulus; a monitor pops them when busy falls.
module tb_ps2_line_interpreter;

    logic         clock;
    logic         reset_n;
    logic [255:0] input_line;
    logic         line_ready;
    logic [31:0]  velocity;
    logic [31:0]  angle;
    logic         fire;
    logic         reset;
    logic         busy;
    logic         cmd_error;

    ps2_line_interpreter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .input_line (input_line),
        .line_ready (line_ready),
        .velocity   (velocity),
        .angle      (angle),
        .fire       (fire),
        .reset      (reset),
        .busy       (busy),
        .cmd_error  (cmd_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] vel;
        logic [31:0] ang;
        logic        f;
        logic        r;
        logic        e;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: a busy falling edge marks the end of a parsed line.
    int busy_prev = 0;
    int bcnt      = 0;
    int chk_next  = 0;
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            busy_prev = 0;
            bcnt      = 0;
            chk_next  = 0;
        end else begin
            if (chk_next != 0) begin
                chk("pulse_width", {29'd0, fire, reset, cmd_error}, 32'd0);
                chk_next = 0;
            end
            if (busy) bcnt++;
            if (busy_prev != 0 && !busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_line: got event want none");
                end else begin
                    e = sb.pop_front();
                    chk("velocity", velocity, e.vel);
                    chk("angle", angle, e.ang);
                    chk("fire", {31'd0, fire}, {31'd0, e.f});
                    chk("reset", {31'd0, reset}, {31'd0, e.r});
                    chk("cmd_error", {31'd0, cmd_error}, {31'd0, e.e});
                    chk("latency", bcnt, e.lat);
                end
                chk_next = 1;
                bcnt     = 0;
            end
            busy_prev = busy ? 1 : 0;
        end
    end

    function automatic logic [255:0] mk_line(input string s);
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < s.len() && i < 32; i++)
            l[255 - 8*i -: 8] = s[i];
        return l;
    endfunction

    task automatic drive_line(input string s);
        @(negedge clock);
        input_line = mk_line(s);
        line_ready = 1'b1;
        @(negedge clock);
        line_ready = 1'b0;
    endtask

    task automatic push(input int lat, input logic [31:0] v,
                        input logic [31:0] a, input logic f,
                        input logic r, input logic e);
        exp_t x;
        x.vel = v;
        x.ang = a;
        x.f   = f;
        x.r   = r;
        x.e   = e;
        x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((busy || sb.size() != 0) && k < 80) begin
            @(negedge clock);
            k++;
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (busy || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got pending=%0d busy=%0b want 0 0",
                     sb.size(), busy);
        end
    endtask

    task automatic send(input string s, input int lat,
                        input logic [31:0] v, input logic [31:0] a,
                        input logic f, input logic r, input logic e);
        push(lat, v, a, f, r, e);
        drive_line(s);
        drain();
    endtask

    localparam logic [31:0] SAT = 32'hFFFF_FFFF;

    initial begin
        logic [31:0] ang_a400;
        logic        err_a400;
        string       s;

`ifdef PS2_INTERP_ANGLE_RANGE_EN
        ang_a400 = 32'd45;
        err_a400 = 1'b1;
`else
        ang_a400 = 32'd400;
        err_a400 = 1'b0;
`endif

        reset_n    = 1'b0;
        input_line = '0;
        line_ready = 1'b0;
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b1;
        @(negedge clock);
        chk("rst_velocity", velocity, 32'd0);
        chk("rst_angle", angle, 32'd0);
        chk("rst_flags", {28'd0, fire, reset, busy, cmd_error}, 32'd0);

        send("V50", 4, 32'd50, 32'd0, 0, 0, 0);
        send("a45", 4, 32'd50, 32'd45, 0, 0, 0);
        send("F", 2, 32'd50, 32'd45, 1, 0, 0);
        send("V4294967299", 12, SAT, 32'd45, 0, 0, 0);
        send("V1x", 3, SAT, 32'd45, 0, 0, 1);
        send("V", 2, SAT, 32'd45, 0, 0, 1);
        send("A400", 5, SAT, ang_a400, 0, 0, err_a400);
        send("", 1, SAT, ang_a400, 0, 0, 0);
        send("r", 2, SAT, ang_a400, 0, 1, 0);
        send("Q5", 1, SAT, ang_a400, 0, 0, 1);
        send("F1", 2, SAT, ang_a400, 0, 0, 1);

        s = "V";
        for (int i = 0; i < 28; i++) s = {s, "0"};
        s = {s, "123"};
        send(s, 32, 32'd123, ang_a400, 0, 0, 0);

        // Second strobe while busy must be dropped silently.
        push(3, 32'd7, ang_a400, 0, 0, 0);
        drive_line("V7");
        input_line = mk_line("A9");
        line_ready = 1'b1;
        @(negedge clock);
        line_ready = 1'b0;
        drain();
        chk("ignored_angle", angle, ang_a400);

        // Abort mid-parse with reset_n.
        drive_line("V12345");
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_velocity", velocity, 32'd0);
        chk("abort_angle", angle, 32'd0);
        chk("abort_flags", {28'd0, fire, reset, busy, cmd_error}, 32'd0);
        repeat (2) @(negedge clock);
        @(posedge clock);
        #3 reset_n = 1'b1;

        send("R", 2, 32'd0, 32'd0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
